// File: rtl/memory_stage.sv
// Memory pipeline stage: holds one instruction from execute, aligns and
// extends load data, and hands results to writeback with forwarding taps.
module memory_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        EM_valid,
  output logic        M_allowin,
  input  logic        W_allowin,
  output logic        MW_valid,
  input  logic [31:0] em_pc,
  input  logic [31:0] em_rf_wdata,
  input  logic        em_gr_we,
  input  logic [4:0]  em_dest,
  input  logic [31:0] em_load_rdata,
  input  logic [1:0]  em_vaddr_lo,
  input  logic [3:0]  em_ld_mask,
  input  logic        em_ld_unsigned,
  input  logic        em_ex,
  input  logic [7:0]  em_ecode,
  input  logic        em_esubcode,
  input  logic [31:0] em_badv,
  input  logic [13:0] em_csr_addr,
  input  logic        em_csr_we,
  input  logic [31:0] em_csr_wmask,
  input  logic [31:0] em_csr_wdata,
  input  logic        ex_en,
  output logic [31:0] mw_pc,
  output logic [31:0] mw_rf_wdata,
  output logic        mw_gr_we,
  output logic [4:0]  mw_dest,
  output logic        mw_ex,
  output logic [7:0]  mw_ecode,
  output logic        mw_esubcode,
  output logic [31:0] mw_badv,
  output logic [13:0] mw_csr_addr,
  output logic        mw_csr_we,
  output logic [31:0] mw_csr_wmask,
  output logic [31:0] mw_csr_wdata,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_wdata,
  output logic        fwd_csr_we,
  output logic [13:0] fwd_csr_addr,
  output logic        ex_M
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rf_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] load_rdata;
    logic [1:0]  vaddr_lo;
    logic [3:0]  ld_mask;
    logic        ld_unsigned;
    logic        ex;
    logic [7:0]  ecode;
    logic        esubcode;
    logic [31:0] badv;
    logic [13:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
  } mem_fields_t;

  mem_fields_t f_q, f_d, f_in;
  logic        m_valid_q, m_valid_d;
  logic        ex_flag_q, ex_flag_d;
  logic [31:0] shifted;
  logic [31:0] ld_val;
  logic        wr_ok;

  assign f_in = '{
    pc:          em_pc,
    rf_wdata:    em_rf_wdata,
    gr_we:       em_gr_we,
    dest:        em_dest,
    load_rdata:  em_load_rdata,
    vaddr_lo:    em_vaddr_lo,
    ld_mask:     em_ld_mask,
    ld_unsigned: em_ld_unsigned,
    ex:          em_ex,
    ecode:       em_ecode,
    esubcode:    em_esubcode,
    badv:        em_badv,
    csr_addr:    em_csr_addr,
    csr_we:      em_csr_we,
    csr_wmask:   em_csr_wmask,
    csr_wdata:   em_csr_wdata
  };

  assign ex_M      = m_valid_q && f_q.ex;
  assign M_allowin = !m_valid_q || W_allowin;
  assign MW_valid  = m_valid_q;

  // ex_en flushes both valid and contents; it beats a same-cycle capture
  always_comb begin
    m_valid_d = m_valid_q;
    f_d       = f_q;
    ex_flag_d = ex_flag_q;
    if (ex_en) begin
      m_valid_d = 1'b0;
      f_d       = '0;
      ex_flag_d = 1'b0;
    end else if (M_allowin) begin
      m_valid_d = EM_valid && !ex_flag_q && !ex_M;
      if (EM_valid) f_d = f_in;
    end
    if (ex_M) ex_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_valid_q <= 1'b0;
      ex_flag_q <= 1'b0;
      f_q       <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      ex_flag_q <= ex_flag_d;
      f_q       <= f_d;
    end
  end

  assign shifted = f_q.load_rdata >> {f_q.vaddr_lo, 3'b000};

  always_comb begin
    ld_val = f_q.load_rdata;
    unique case (1'b1)
      f_q.ld_mask == 4'b0001:
        ld_val = {{24{!f_q.ld_unsigned && shifted[7]}}, shifted[7:0]};
      f_q.ld_mask == 4'b0011:
        ld_val = {{16{!f_q.ld_unsigned && shifted[15]}}, shifted[15:0]};
      default:
        ld_val = f_q.load_rdata;
    endcase
  end

  assign wr_ok       = m_valid_q && !ex_M;
  assign mw_rf_wdata = (f_q.ld_mask != 4'b0000 && !f_q.ex) ? ld_val
                                                           : f_q.rf_wdata;
  assign mw_pc        = f_q.pc;
  assign mw_gr_we     = f_q.gr_we && wr_ok;
  assign mw_dest      = f_q.dest;
  assign mw_ex        = f_q.ex;
  assign mw_ecode     = f_q.ecode;
  assign mw_esubcode  = f_q.esubcode;
  assign mw_badv      = f_q.badv;
  assign mw_csr_addr  = f_q.csr_addr;
  assign mw_csr_we    = f_q.csr_we && wr_ok;
  assign mw_csr_wmask = f_q.csr_wmask;
  assign mw_csr_wdata = f_q.csr_wdata;

  assign fwd_dest     = (wr_ok && f_q.gr_we) ? f_q.dest : 5'd0;
  assign fwd_wdata    = mw_rf_wdata;
  assign fwd_csr_we   = wr_ok && f_q.csr_we;
  assign fwd_csr_addr = f_q.csr_addr;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: scoreboard of expected handoffs
// plus immediate checks on handshake, exception and reset behaviour.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        EM_valid, M_allowin, W_allowin, MW_valid;
  logic [31:0] em_pc, em_rf_wdata, em_load_rdata, em_badv;
  logic        em_gr_we, em_ld_unsigned, em_ex, em_esubcode, em_csr_we;
  logic [4:0]  em_dest;
  logic [1:0]  em_vaddr_lo;
  logic [3:0]  em_ld_mask;
  logic [7:0]  em_ecode;
  logic [13:0] em_csr_addr;
  logic [31:0] em_csr_wmask, em_csr_wdata;
  logic        ex_en;
  logic [31:0] mw_pc, mw_rf_wdata, mw_badv, mw_csr_wmask, mw_csr_wdata;
  logic        mw_gr_we, mw_ex, mw_esubcode, mw_csr_we;
  logic [4:0]  mw_dest, fwd_dest;
  logic [7:0]  mw_ecode;
  logic [13:0] mw_csr_addr, fwd_csr_addr;
  logic [31:0] fwd_wdata;
  logic        fwd_csr_we, ex_M;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  memory_stage dut (
    .clk(clk), .rstn(rstn),
    .EM_valid(EM_valid), .M_allowin(M_allowin),
    .W_allowin(W_allowin), .MW_valid(MW_valid),
    .em_pc(em_pc), .em_rf_wdata(em_rf_wdata),
    .em_gr_we(em_gr_we), .em_dest(em_dest),
    .em_load_rdata(em_load_rdata), .em_vaddr_lo(em_vaddr_lo),
    .em_ld_mask(em_ld_mask), .em_ld_unsigned(em_ld_unsigned),
    .em_ex(em_ex), .em_ecode(em_ecode),
    .em_esubcode(em_esubcode), .em_badv(em_badv),
    .em_csr_addr(em_csr_addr), .em_csr_we(em_csr_we),
    .em_csr_wmask(em_csr_wmask), .em_csr_wdata(em_csr_wdata),
    .ex_en(ex_en),
    .mw_pc(mw_pc), .mw_rf_wdata(mw_rf_wdata),
    .mw_gr_we(mw_gr_we), .mw_dest(mw_dest),
    .mw_ex(mw_ex), .mw_ecode(mw_ecode),
    .mw_esubcode(mw_esubcode), .mw_badv(mw_badv),
    .mw_csr_addr(mw_csr_addr), .mw_csr_we(mw_csr_we),
    .mw_csr_wmask(mw_csr_wmask), .mw_csr_wdata(mw_csr_wdata),
    .fwd_dest(fwd_dest), .fwd_wdata(fwd_wdata),
    .fwd_csr_we(fwd_csr_we), .fwd_csr_addr(fwd_csr_addr),
    .ex_M(ex_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [31:0] wd, input logic gwe,
                       input logic [4:0] dst, input logic [31:0] rd,
                       input logic [1:0] vlo, input logic [3:0] msk,
                       input logic uns, input logic ex,
                       input logic [7:0] ec, input logic cwe);
    EM_valid       = v;
    em_pc          = pc;
    em_rf_wdata    = wd;
    em_gr_we       = gwe;
    em_dest        = dst;
    em_load_rdata  = rd;
    em_vaddr_lo    = vlo;
    em_ld_mask     = msk;
    em_ld_unsigned = uns;
    em_ex          = ex;
    em_ecode       = ec;
    em_esubcode    = 1'b0;
    em_badv        = pc ^ 32'hFFFF_0000;
    em_csr_addr    = pc[13:0];
    em_csr_we      = cwe;
    em_csr_wmask   = 32'hFFFF_FFFF;
    em_csr_wdata   = wd;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] wd);
    exp_t e;
    e.pc    = pc;
    e.wdata = wd;
    sb.push_back(e);
  endtask

  // One clock; retire the head entry on a handoff, then check the new head
  task automatic step();
    logic hand;
    hand = (MW_valid === 1'b1) && W_allowin;
    @(posedge clk);
    #1;
    if (hand && sb.size() > 0) void'(sb.pop_front());
    if (MW_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", {31'd0, MW_valid}, 32'd0);
      end else begin
        chk("sb_pc", mw_pc, sb[0].pc);
        chk("sb_wdata", mw_rf_wdata, sb[0].wdata);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    W_allowin = 1'b1;
    ex_en = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_mw_valid", {31'd0, MW_valid}, 32'd0);
    chk("rst_allowin", {31'd0, M_allowin}, 32'd1);
    chk("rst_ex_m", {31'd0, ex_M}, 32'd0);
    chk("rst_fwd_dest", {27'd0, fwd_dest}, 32'd0);
    chk("rst_fwd_csr_we", {31'd0, fwd_csr_we}, 32'd0);
    rstn = 1'b1;

    // back-to-back loads and a csr op
    drive(1, 32'h100, 32'h5, 1, 5'd5, 32'h12AB_80FF, 2, 4'b0001, 0, 0, 0, 0);
    push(32'h100, 32'hFFFF_FFAB);
    step();
    chk("b2b_v0", {31'd0, MW_valid}, 32'd1);
    chk("fwd_dest_ldb", {27'd0, fwd_dest}, 32'd5);
    chk("fwd_wdata_ldb", fwd_wdata, 32'hFFFF_FFAB);
    drive(1, 32'h104, 32'h6, 1, 5'd6, 32'h12AB_80FF, 2, 4'b0011, 1, 0, 0, 0);
    push(32'h104, 32'h0000_12AB);
    step();
    chk("b2b_v1", {31'd0, MW_valid}, 32'd1);
    drive(1, 32'h108, 32'h7, 1, 5'd7, 32'h12AB_80FF, 2, 4'b1111, 0, 0, 0, 0);
    push(32'h108, 32'h12AB_80FF);
    step();
    chk("b2b_v2", {31'd0, MW_valid}, 32'd1);
    drive(1, 32'h10C, 32'h8, 1, 5'd8, 32'h12AB_80FF, 1, 4'b0001, 1, 0, 0, 0);
    push(32'h10C, 32'h0000_0080);
    step();
    drive(1, 32'h110, 32'h9, 1, 5'd9, 32'h12AB_80FF, 0, 4'b0011, 0, 0, 0, 0);
    push(32'h110, 32'hFFFF_80FF);
    step();
    drive(1, 32'h114, 32'hDEAD_BEEF, 0, 5'd10, 32'h0, 0, 4'b0000, 0, 0, 0, 1);
    push(32'h114, 32'hDEAD_BEEF);
    step();
    chk("csr_fwd_we", {31'd0, fwd_csr_we}, 32'd1);
    chk("csr_fwd_addr", {18'd0, fwd_csr_addr}, 32'h114);
    chk("csr_fwd_dest", {27'd0, fwd_dest}, 32'd0);
    chk("csr_mw_we", {31'd0, mw_csr_we}, 32'd1);
    EM_valid = 1'b0;
    step();
    chk("b2b_drain", {31'd0, MW_valid}, 32'd0);

    // stall: A held four cycles while B waits upstream
    drive(1, 32'h200, 32'h1111_1111, 1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
    push(32'h200, 32'h1111_1111);
    step();
    W_allowin = 1'b0;
    drive(1, 32'h204, 32'h2222_2222, 1, 5'd8, 0, 0, 0, 0, 0, 0, 0);
    push(32'h204, 32'h2222_2222);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_allowin", {31'd0, M_allowin}, 32'd0);
      chk("stall_valid", {31'd0, MW_valid}, 32'd1);
      chk("stall_dest", {27'd0, mw_dest}, 32'd7);
    end
    W_allowin = 1'b1;
    step();
    chk("stall_release_pc", mw_pc, 32'h204);
    EM_valid = 1'b0;
    step();

    // exception, drop until ex_en, ex_en together with EM_valid
    drive(1, 32'h300, 32'h33, 1, 5'd9, 0, 0, 4'b0001, 0, 1, 8'h09, 1);
    push(32'h300, 32'h33);
    step();
    chk("ex_m", {31'd0, ex_M}, 32'd1);
    chk("ex_gr_we", {31'd0, mw_gr_we}, 32'd0);
    chk("ex_csr_we", {31'd0, mw_csr_we}, 32'd0);
    chk("ex_fwd_dest", {27'd0, fwd_dest}, 32'd0);
    chk("ex_ecode", {24'd0, mw_ecode}, 32'h09);
    drive(1, 32'h304, 32'h44, 1, 5'd10, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("ex_drop0", {31'd0, MW_valid}, 32'd0);
    step();
    chk("ex_drop1", {31'd0, MW_valid}, 32'd0);
    ex_en = 1'b1;
    step();
    chk("exen_same_cycle", {31'd0, MW_valid}, 32'd0);
    ex_en = 1'b0;
    drive(1, 32'h308, 32'h55, 1, 5'd11, 0, 0, 0, 0, 0, 0, 0);
    push(32'h308, 32'h55);
    step();
    chk("post_flush_valid", {31'd0, MW_valid}, 32'd1);
    chk("post_flush_fwd", {27'd0, fwd_dest}, 32'd11);
    EM_valid = 1'b0;
    step();

    // reset during a stall
    drive(1, 32'h400, 32'h66, 1, 5'd3, 0, 0, 0, 0, 0, 0, 0);
    push(32'h400, 32'h66);
    step();
    W_allowin = 1'b0;
    EM_valid = 1'b0;
    step();
    chk("pre_rst_valid", {31'd0, MW_valid}, 32'd1);
    rstn = 1'b0;
    sb.delete();
    step();
    chk("rst_stall_valid", {31'd0, MW_valid}, 32'd0);
    chk("rst_stall_fwd", {27'd0, fwd_dest}, 32'd0);
    chk("rst_stall_allowin", {31'd0, M_allowin}, 32'd1);
    rstn = 1'b1;
    W_allowin = 1'b1;
    step();
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-002 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port EM_valid, input, 1: upstream (execute) has an instruction to hand over.
REQ-004 SHALL have port M_allowin, output, 1: this stage accepts a new instruction this cycle.
REQ-005 SHALL have port W_allowin, input, 1: writeback stage accepts an instruction.
REQ-006 SHALL have port MW_valid, output, 1: this stage hands an instruction to writeback.
REQ-007 SHALL have inputs em_pc (32), em_rf_wdata (32), em_gr_we (1), em_dest (5), em_load_rdata (32) and em_vaddr_lo (2).
REQ-008 SHALL have inputs em_ld_mask (4; 0001 byte, 0011 half, 1111 word, 0000 not a load), em_ld_unsigned (1), em_ex (1), em_ecode (8), em_esubcode (1) and em_badv (32).
REQ-009 SHALL have inputs em_csr_addr (14), em_csr_we (1), em_csr_wmask (32) and em_csr_wdata (32).
REQ-010 SHALL have input ex_en, 1: exception/ertn commit flush from writeback.
REQ-011 SHALL have outputs mw_pc, mw_rf_wdata (32), mw_gr_we, mw_dest (5), mw_ex, mw_ecode (8), mw_esubcode, mw_badv (32), mw_csr_addr (14), mw_csr_we, mw_csr_wmask (32) and mw_csr_wdata (32), all registered-stage fields.
REQ-012 SHALL have outputs fwd_dest (5), fwd_wdata (32), fwd_csr_we (1) and fwd_csr_addr (14): forwarding to decode.
REQ-013 SHALL have output ex_M, 1: the valid instruction in this stage carries an exception.

Function
REQ-014 SHALL keep M_valid plus one pipeline register holding all em_* fields; capture it when EM_valid && M_allowin && !ex_en.
REQ-015 SHALL drive M_ready_go = 1; M_allowin = !M_valid || W_allowin; MW_valid = M_valid.
REQ-016 SHALL update M_valid, when M_allowin && !ex_en, to EM_valid && !ex_flag && !ex_M.
REQ-017 SHALL clear M_valid and the field register on ex_en, regardless of EM_valid/W_allowin (ex_en wins over capture).
REQ-018 SHALL set ex_flag when ex_M = 1 and clear it on ex_en (ex_M wins if both, since ex_en also flushes M); while ex_flag = 1 all incoming instructions are dropped (valid forced 0).
REQ-019 SHALL compute ex_M = M_valid && em_ex_reg.
REQ-020 SHALL align loads: shifted = load_rdata >> (8*vaddr_lo).
REQ-021 SHALL extend the aligned load: byte from shifted[7:0], half from shifted[15:0], zero-extended if ld_unsigned else sign-extended; word uses load_rdata unshifted.
REQ-022 SHALL set mw_rf_wdata = aligned load value if ld_mask != 0 and no exception, else rf_wdata_reg.
REQ-023 SHALL force mw_gr_we = 0 and mw_csr_we = 0 when ex_M or !M_valid.
REQ-024 SHALL set fwd_dest = dest_reg when M_valid && gr_we_reg && !ex_M, else 0; fwd_wdata = mw_rf_wdata.
REQ-025 SHALL set fwd_csr_we = M_valid && csr_we_reg && !ex_M and fwd_csr_addr = csr_addr_reg.
REQ-026 SHALL, when W_allowin = 0 with M_valid = 1, hold all registered fields stable and keep MW_valid = 1 (no loss, no duplication).
REQ-027 SHALL have the register advance in the same cycle when M_valid && W_allowin && EM_valid (back-to-back throughput 1/cycle).

Reset
REQ-028 SHALL, with rstn = 0 at a clock edge, clear M_valid, ex_flag and all field registers to 0; consequently MW_valid = 0, ex_M = 0, fwd_dest = 0, fwd_csr_we = 0 and M_allowin = 1.
REQ-029 SHALL have reset take priority over ex_en and capture, including reset arriving mid-stall.

Verification
REQ-030 SHALL be checked by this scenario: ld.b, rdata = 0x12AB_80FF, vaddr_lo = 2, signed -> mw_rf_wdata = 0xFFFF_FFAB; ld.hu, vaddr_lo = 2 -> 0x0000_12AB; ld.w -> 0x12AB_80FF.
REQ-031 SHALL be checked by this scenario: 3 back-to-back instructions with W_allowin = 1 -> MW_valid high 3 consecutive cycles, one cycle after each capture.
REQ-032 SHALL be checked by this scenario: W_allowin = 0 for 4 cycles with M_valid = 1 -> M_allowin = 0, outputs unchanged; then W_allowin = 1 -> next instruction captured that edge.
REQ-033 SHALL be checked by this scenario: instruction with em_ex = 1, ecode 0x09 -> ex_M = 1, mw_gr_we = 0, fwd_dest = 0; following EM_valid instructions dropped until ex_en pulse, then M_valid = 0 and the next instruction accepted.
REQ-034 SHALL be checked by this scenario: ex_en and EM_valid in the same cycle -> M_valid = 0 next cycle.
REQ-035 SHALL be checked by this scenario: rstn low during a stall -> MW_valid = 0 and fwd_dest = 0 the following cycle.
